// File: rtl/decode_stage.sv
// Decode stage: IF/ID register pair, load-use hazard detection, redirect squash
// and combinational RV32 field/immediate decode of the held instruction.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pcIn,
    input  logic        pcWriteEnable,
    input  logic        memReadEnable,
    input  logic [4:0]  exRegWriteNum,
    output logic [31:0] PC,
    output logic [31:0] imm,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [6:0]  opcode,
    output logic [4:0]  regNum0,
    output logic [4:0]  regNum1,
    output logic [4:0]  regWriteNum,
    output logic        flush,
    output logic        hazard,
    output logic        fetchStall
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = 7;
    localparam int unsigned REGW  = 5;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [OPW-1:0] OP_R      = 7'b0110011;
    localparam logic [OPW-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SQUASH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] ir_instr_q, ir_instr_d;
    logic [XLEN-1:0] ir_pc_q, ir_pc_d;

    logic            use_rs0;
    logic            use_rs1;
    logic            hazard_c;

    // IF/ID pair and state; reset parks a NOP in decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            ir_instr_q <= NOP_INSTR;
            ir_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_instr_q <= ir_instr_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

    // Field extraction, format-dependent register masking and immediate build
    always_comb begin
        opcode      = ir_instr_q[6:0];
        func3       = ir_instr_q[14:12];
        func7       = ir_instr_q[31:25];
        regNum0     = ir_instr_q[19:15];
        regNum1     = ir_instr_q[24:20];
        regWriteNum = ir_instr_q[11:7];
        PC          = ir_pc_q;
        imm         = '0;
        use_rs0     = 1'b0;
        use_rs1     = 1'b0;
        case (ir_instr_q[6:0])
            OP_R: begin
                use_rs0 = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                use_rs0 = 1'b1;
                regNum1 = '0;
                imm     = {{20{ir_instr_q[31]}}, ir_instr_q[31:20]};
            end
            OP_STORE: begin
                use_rs0     = 1'b1;
                use_rs1     = 1'b1;
                regWriteNum = '0;
                imm         = {{20{ir_instr_q[31]}}, ir_instr_q[31:25], ir_instr_q[11:7]};
            end
            OP_BRANCH: begin
                use_rs0     = 1'b1;
                use_rs1     = 1'b1;
                regWriteNum = '0;
                imm         = {{19{ir_instr_q[31]}}, ir_instr_q[31], ir_instr_q[7],
                               ir_instr_q[30:25], ir_instr_q[11:8], 1'b0};
            end
            OP_JAL: begin
                regNum0 = '0;
                regNum1 = '0;
                imm     = {{11{ir_instr_q[31]}}, ir_instr_q[31], ir_instr_q[19:12],
                           ir_instr_q[20], ir_instr_q[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                regNum0 = '0;
                regNum1 = '0;
                imm     = {ir_instr_q[31:12], 12'b0};
            end
            default: begin
                imm = '0;
            end
        endcase
    end

    // Load-use detection; only meaningful in RUN with no redirect pending
    always_comb begin
        hazard_c = 1'b0;
        if (!reset && state_q == RUN && !pcWriteEnable && memReadEnable
            && exRegWriteNum != REGW'(0)) begin
            hazard_c = (use_rs0 && exRegWriteNum == regNum0)
                    || (use_rs1 && exRegWriteNum == regNum1);
        end
    end

    // Next-state and pipeline control: redirect beats hazard
    always_comb begin
        state_d    = RUN;
        ir_instr_d = instr;
        ir_pc_d    = pcIn;
        fetchStall = 1'b0;
        hazard     = hazard_c;
        flush      = reset || pcWriteEnable || hazard_c || (state_q == SQUASH);
        if (pcWriteEnable) begin
            state_d    = SQUASH;
            ir_instr_d = NOP_INSTR;
            ir_pc_d    = ir_pc_q;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard_c) begin
                        state_d    = STALL;
                        ir_instr_d = ir_instr_q;
                        ir_pc_d    = ir_pc_q;
                        fetchStall = 1'b1;
                    end
                end
                STALL: begin
                    state_d = RUN;
                end
                SQUASH: begin
                    state_d    = RUN;
                    ir_instr_d = NOP_INSTR;
                    ir_pc_d    = ir_pc_q;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high reset (one clock; asynchronous, active-high).
REQ-002 SHALL have inputs: instr in 32, fetched instruction; pcIn in 32, address of instr; pcWriteEnable in 1, execute-stage redirect; memReadEnable in 1, load in execute; exRegWriteNum in 5, execute-stage destination register.
REQ-003 SHALL have outputs: PC out 32; imm out 32; func3 out 3; func7 out 7; opcode out 7; regNum0, regNum1, regWriteNum out 5 each; flush out 1; hazard out 1; fetchStall out 1.

Function
REQ-004 SHALL hold the IF/ID register pair (irInstr, irPC); all decode outputs SHALL derive combinationally from irInstr and irPC only.
REQ-005 SHALL have a 2-bit state machine with states RUN=0, STALL=1, SQUASH=2.
REQ-006 SHALL, in RUN with no redirect and no hazard, load irInstr<=instr and irPC<=pcIn on each rising edge.
REQ-007 SHALL assert hazard combinationally when memReadEnable=1, exRegWriteNum!=0, and exRegWriteNum equals a used source (regNum0 for R/I/load/S/B/jalr; regNum1 for R/S/B).
REQ-008 SHALL, on hazard without redirect: hold irInstr/irPC, assert fetchStall, assert flush (bubble into execute), and enter STALL for one cycle.
REQ-009 SHALL, in STALL, force hazard=0 and return to RUN on the next edge, then load the fetched instr normally; total load-use penalty is exactly 1 cycle.
REQ-010 SHALL, on pcWriteEnable=1 in any state: load irInstr<=0x00000013 (NOP), hold irPC, assert flush in the same cycle, and enter SQUASH.
REQ-011 SHALL, in SQUASH, assert flush, load irInstr<=0x00000013 again, and return to RUN; a redirect therefore kills exactly 2 younger instructions.
REQ-012 SHALL give redirect priority over hazard; hazard SHALL be masked when pcWriteEnable=1 or state!=RUN.
REQ-013 SHALL drive fetchStall=1 only on a hazard cycle (REQ-008); otherwise 0.
REQ-014 SHALL decode opcode=irInstr[6:0], func3=[14:12], func7=[31:25], regNum0=[19:15], regNum1=[24:20], regWriteNum=[11:7], PC=irPC.
REQ-015 SHALL force regWriteNum=0 for S (0100011) and B (1100011); regNum0=0 for lui, auipc, jal; regNum1=0 for all formats except R, S, B.
REQ-016 SHALL sign-extend imm from bit 31: I (0010011, 0000011, 1100111) = instr[31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; J = {[31],[19:12],[20],[30:21],0}.
REQ-017 SHALL set imm = {instr[31:12], 12'b0} for lui (0110111) and auipc (0010111), and imm=0 for R and unknown opcodes.
REQ-018 SHALL pass unknown opcodes through unmodified except imm=0; downstream treats them as idle.

Reset
REQ-019 SHALL, on reset asserted (asynchronously, independent of clk), set state=RUN, irInstr=0x00000013, irPC=0.
REQ-020 SHALL, during reset, drive flush=1, hazard=0, fetchStall=0, PC=0, opcode=0010011, imm=0, all register numbers 0.
REQ-021 SHALL, on reset asserted mid-STALL or mid-SQUASH, abandon that state immediately; first edge after release loads instr.

Verification
REQ-022 Straight-line: instr=0x00500093 (addi x1,x0,5) at pcIn=0x10 -> next cycle opcode=0010011, regWriteNum=1, regNum0=0, imm=5, PC=0x10, flush=0.
REQ-023 Load-use: lw x2 in execute (memReadEnable=1, exRegWriteNum=2), ID holds add x3,x2,x1 -> hazard=1, flush=1, fetchStall=1 one cycle; ID unchanged next cycle, hazard=0.
REQ-024 Redirect: pcWriteEnable=1 for one cycle -> flush=1 that cycle and the next, ID shows NOP (0x00000013) for 2 cycles, then resumes from pcIn.
REQ-025 Redirect+hazard same cycle -> flush=1, hazard=0, fetchStall=0, state SQUASH.
REQ-026 Immediates: instr=0xFE000EE3 (beq, offset -4) -> imm=0xFFFFFFFC; 0x800000EF (jal) -> imm=0xFFF00000; 0x123450B7 (lui) -> imm=0x12345000.
REQ-027 Async reset: assert reset between edges while in STALL -> outputs take reset values before next edge; x0 source with memReadEnable=1, exRegWriteNum=0 -> hazard=0.
